// File: rtl/data_memory_sync.sv
// Byte-addressed big-endian data RAM with wait states, Ready/Fault handshake.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses instead of aligning them.
module data_memory_sync #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [31:0]           DI,
  output logic [31:0]           DO,
  input  logic [1:0]            Size,
  input  logic                  RW,
  input  logic                  E,
  input  logic                  SE,
  output logic                  Ready,
  output logic                  Fault
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [31:0]           di_q;
  logic [1:0]            size_q;
  logic                  rw_q, se_q;
  logic [31:0]           do_q;
  logic                  fault_q;
  logic [7:0]            mem [DEPTH];

  logic                  capture, exec;
  logic [ADDR_WIDTH-1:0] req_a, acc_a, a0, a1, a2, a3;
  logic [31:0]           req_di, rdata, last_a;
  logic [1:0]            req_size;
  logic                  req_rw, req_se, req_fault, misalign;
  logic [2:0]            nm1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (E) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    Ready = (state_q == StDone);
    Fault = Ready & fault_q;
  end

  assign DO   = do_q;
  assign exec = (state_q != StDone) && (state_d == StDone);

  // With no wait states the access executes on the capture edge, from the live inputs
  assign req_a    = (state_q == StIdle) ? A    : a_q;
  assign req_di   = (state_q == StIdle) ? DI   : di_q;
  assign req_size = (state_q == StIdle) ? Size : size_q;
  assign req_rw   = (state_q == StIdle) ? RW   : rw_q;
  assign req_se   = (state_q == StIdle) ? SE   : se_q;

  always_comb begin
    acc_a    = req_a;
    misalign = 1'b0;
    nm1      = 3'd0;
    unique case (req_size)
      2'b01: begin
        nm1      = 3'd1;
        misalign = req_a[0];
        if (!AlignCheck) acc_a[0] = 1'b0;
      end
      2'b10: begin
        nm1      = 3'd3;
        misalign = |req_a[1:0];
        if (!AlignCheck) acc_a[1:0] = 2'b00;
      end
      default: ;
    endcase
    last_a    = 32'(acc_a) + 32'(nm1);
    req_fault = (req_size == 2'b11) | (AlignCheck & misalign) | (last_a >= DEPTH);
  end

  assign a0 = acc_a;
  assign a1 = acc_a + ADDR_WIDTH'(1);
  assign a2 = acc_a + ADDR_WIDTH'(2);
  assign a3 = acc_a + ADDR_WIDTH'(3);

  always_comb begin
    rdata = do_q;
    unique case (req_size)
      2'b00:   rdata = {{24{req_se & mem[a0][7]}}, mem[a0]};
      2'b01:   rdata = {{16{req_se & mem[a0][7]}}, mem[a0], mem[a1]};
      2'b10:   rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: rdata = do_q;
    endcase
  end

  // Request capture, read data and fault flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      di_q    <= '0;
      size_q  <= '0;
      rw_q    <= 1'b0;
      se_q    <= 1'b0;
      do_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      if (capture) begin
        a_q    <= A;
        di_q   <= DI;
        size_q <= Size;
        rw_q   <= RW;
        se_q   <= SE;
      end
      if (exec) begin
        fault_q <= req_fault;
        if (!req_fault && !req_rw) do_q <= rdata;
      end
    end
  end

  // Storage is not reset; a reset edge only blocks the write
  always_ff @(posedge clk) begin
    if (rst_n && exec && req_rw && !req_fault) begin
      unique case (req_size)
        2'b00: mem[a0] <= req_di[7:0];
        2'b01: begin
          mem[a0] <= req_di[15:8];
          mem[a1] <= req_di[7:0];
        end
        2'b10: begin
          mem[a0] <= req_di[31:24];
          mem[a1] <= req_di[23:16];
          mem[a2] <= req_di[15:8];
          mem[a3] <= req_di[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// Randomised bench for data_memory_sync: instance 0 with no wait states (256 B),
// instance 1 with three wait states (192 B), both checked against a byte-array model.
module tb_data_memory_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a     [2];
  logic [31:0] di    [2];
  logic [31:0] dout  [2];
  logic [1:0]  sz    [2];
  logic        rw    [2];
  logic        e     [2];
  logic        se    [2];
  logic        ready [2];
  logic        fault [2];

  logic [7:0]  mm  [2][256];
  logic [31:0] mdo [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  data_memory_sync #(.ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .A(a[0]), .DI(di[0]), .DO(dout[0]), .Size(sz[0]),
    .RW(rw[0]), .E(e[0]), .SE(se[0]), .Ready(ready[0]), .Fault(fault[0])
  );

  data_memory_sync #(.ADDR_WIDTH(8), .DEPTH(192), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(a[1]), .DI(di[1]), .DO(dout[1]), .Size(sz[1]),
    .RW(rw[1]), .E(e[1]), .SE(se[1]), .Ready(ready[1]), .Fault(fault[1])
  );

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int depth(input int d);
    return (d == 0) ? 256 : 192;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies one access to the model; returns whether it faults
  function automatic bit model(input int d, input bit w, input bit [1:0] s, input int ad,
                               input bit [31:0] wd, input bit sx);
    int        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    int        b = ad;
    bit        xf = (s == 2'd3);
    bit [31:0] v = 0;
    if (!xf) begin
`ifdef DMEM_ALIGN_CHECK_EN
      if (b % n != 0) xf = 1'b1;
`else
      b = b - (b % n);
`endif
      if (b + n - 1 >= depth(d)) xf = 1'b1;
    end
    if (!xf) begin
      if (w) begin
        for (int i = 0; i < n; i++) mm[d][b+i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[d][b+i]);
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        mdo[d] = v;
      end
    end
    return xf;
  endfunction

  task automatic access(input int d, input bit w, input bit [1:0] s, input int ad,
                        input bit [31:0] wd, input bit sx, input bit poke,
                        output logic [31:0] got);
    bit xf;
    int cyc   = 0;
    int extra = 0;
    xf = model(d, w, s, ad, wd, sx);
    @(negedge clk);
    a[d] = 8'(ad); di[d] = wd; sz[d] = s; rw[d] = w; se[d] = sx; e[d] = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the access in flight must not see them
    e[d] = 1'b0; a[d] = 8'($urandom); di[d] = $urandom; sz[d] = 2'($urandom);
    rw[d] = 1'($urandom); se[d] = 1'($urandom);
    while (!ready[d] && cyc < 40) begin
      if (poke) e[d] = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(ws(d)));
    check_eq("fault", 32'(fault[d]), 32'(xf));
    check_eq("do", dout[d], mdo[d]);
    got = dout[d];
    if (poke) e[d] = 1'b1;
    for (int i = 0; i < ws(d) + 2; i++) begin
      @(posedge clk); #1;
      e[d] = 1'b0;
      if (ready[d] || fault[d]) extra++;
    end
    check_eq("quiet_after", 32'(extra), 32'd0);
  endtask

  logic [31:0] got;
  bit          xf;
  int          first, second, extra;

  initial begin
    for (int d = 0; d < 2; d++) begin
      a[d] = '0; di[d] = '0; sz[d] = '0; rw[d] = 1'b0; e[d] = 1'b0; se[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_do", dout[d], 32'h0);
      check_eq("rst_ready", 32'(ready[d]), 32'h0);
      check_eq("rst_fault", 32'(fault[d]), 32'h0);
      mdo[d] = 32'h0;
    end
    rst_n = 1'b1;

    // Give every byte a known value
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < depth(d); w += 4) access(d, 1'b1, 2'd2, w, $urandom, 1'b0, 1'b0, got);

    for (int d = 0; d < 2; d++) begin
      access(d, 1'b1, 2'd2, 'h0C, 32'h3344_5566, 1'b0, 1'b0, got);
      access(d, 1'b0, 2'd2, 'h0C, 32'h0, 1'b0, 1'b0, got);
      check_eq("word_rt", got, 32'h3344_5566);
      access(d, 1'b1, 2'd0, 'h00, 32'h0000_00A6, 1'b0, 1'b0, got);
      access(d, 1'b1, 2'd0, 'h02, 32'h0000_00DD, 1'b0, 1'b0, got);
      access(d, 1'b1, 2'd1, 'h04, 32'h0000_ABCD, 1'b0, 1'b0, got);
      access(d, 1'b1, 2'd1, 'h06, 32'h0000_EF01, 1'b0, 1'b0, got);
      access(d, 1'b0, 2'd2, 'h00, 32'h0, 1'b0, 1'b0, got);
      check_eq("be_word0", got & 32'hFF00_FF00, 32'hA600_DD00);
      access(d, 1'b0, 2'd2, 'h04, 32'h0, 1'b0, 1'b0, got);
      check_eq("be_word4", got, 32'hABCD_EF01);
      access(d, 1'b0, 2'd1, 'h04, 32'h0, 1'b0, 1'b0, got);
      check_eq("half_zx", got, 32'h0000_ABCD);
      access(d, 1'b0, 2'd1, 'h04, 32'h0, 1'b1, 1'b0, got);
      check_eq("half_sx", got, 32'hFFFF_ABCD);
      access(d, 1'b0, 2'd0, 'h00, 32'h0, 1'b1, 1'b0, got);
      check_eq("byte_sx", got, 32'hFFFF_FFA6);
      access(d, 1'b0, 2'd3, 'h08, 32'h0, 1'b0, 1'b0, got);
      access(d, 1'b1, 2'd2, depth(d) - 2, 32'h1122_3344, 1'b0, 1'b0, got);
      access(d, 1'b0, 2'd2, depth(d) - 4, 32'h0, 1'b0, 1'b0, got);
      access(d, 1'b0, 2'd1, 'h05, 32'h0, 1'b0, 1'b0, got);
`ifndef DMEM_ALIGN_CHECK_EN
      check_eq("half_align", got, 32'h0000_ABCD);
`endif
    end

    // E pulses while busy or done must not start a second access
    access(1, 1'b0, 2'd2, 'h08, 32'h0, 1'b0, 1'b1, got);

    // Back-to-back reads with E held high
    xf = model(1, 1'b0, 2'd2, 'h04, 32'h0, 1'b0);
    first = -1; second = -1;
    @(negedge clk);
    a[1] = 8'h04; sz[1] = 2'd2; rw[1] = 1'b0; se[1] = 1'b0; e[1] = 1'b1;
    for (int c = 0; c < 30 && second < 0; c++) begin
      @(posedge clk); #1;
      if (ready[1]) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    e[1] = 1'b0;
    check_eq("first_ready", 32'(first), 32'd3);
    check_eq("throughput", 32'(second - first), 32'd5);
    check_eq("thru_do", dout[1], mdo[1]);
    repeat (2) @(posedge clk);

    // Reset while busy abandons a write
    @(negedge clk);
    a[1] = 8'h10; di[1] = 32'hDEAD_BEEF; sz[1] = 2'd2; rw[1] = 1'b1; e[1] = 1'b1;
    @(posedge clk); #1;
    e[1] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[1]) extra++;
    end
    check_eq("abandoned", 32'(extra), 32'd0);
    check_eq("rst_do_mid", dout[1], 32'h0);
    mdo[0] = 32'h0; mdo[1] = 32'h0;
    access(1, 1'b0, 2'd2, 'h10, 32'h0, 1'b0, 1'b0, got);

    for (int k = 0; k < 300; k++) begin
      int        d  = int'($urandom_range(0, 1));
      bit [1:0]  s  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      int        ad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 31));
      access(d, 1'($urandom), s, ad, $urandom, 1'($urandom),
             $urandom_range(0, 7) == 0, got);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
